control_fsm: RTL
================

Name: control_fsm

Overview:
- Multi-cycle RV32I/RV32E control unit; the successor to the single-state LUI/AUIPC decoder.
- Sequences fetch, execute, memory and trap states with valid/ready handshakes toward instruction and data memory.
- Decodes LUI, AUIPC, OP-IMM, OP, LOAD, STORE, JAL, JALR and BRANCH.
- Drives the register file, ALU mux selects and PC next-select, sitting between the fetch unit and the datapath.

Parameters:
- REG_IDX_W, 5, register index width: 5 for RV32I, 4 for RV32E.
- RESET_CYCLES, 2, cycles held in ST_RESET after rstn_i deasserts (min 1).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- fetch_req_o  out  1  instruction fetch request
- fetch_valid_i  in  1  instr_i valid this cycle
- instr_i  in  32  fetched instruction
- mem_req_o  out  1  data memory request
- mem_we_o  out  1  1 = store, 0 = load
- mem_ready_i  in  1  data access completes this cycle
- branch_cond_i  in  1  external comparator result for the decoded funct3
- wr_en_o  out  1  register file write enable
- rd_idx_o  out  REG_IDX_W  destination register
- rs1_idx_o  out  REG_IDX_W  source 1
- rs2_idx_o  out  REG_IDX_W  source 2
- imm_data_o  out  32  sign-extended immediate (I/S/B/U/J formats)
- alu_ctrl_o  out  4  ALU opcode (ALU_OP_* constants)
- alu_a_input_o  out  1  0: rs1, 1: pc
- alu_b_input_o  out  1  0: imm, 1: rs2
- reg_input_o  out  2  0: alu, 1: mem, 2: pc+4
- pc_sel_next_o  out  2  0: hold, 1: pc+4, 2: alu result
- illegal_o  out  1  illegal-instruction flag (see Optional Feature)

Behaviour:
- Reset: async on rstn_i low.
  - State ST_RESET; ir register = 0; reset counter = 0.
  - All outputs 0; alu_ctrl_o = ALU_OP_ADD.
  - Reset asserted mid-operation abandons any fetch or memory transaction immediately; no write enable is asserted on the reset edge.
- States: ST_RESET, ST_FETCH, ST_EXEC, ST_MEM, ST_TRAP.
- ST_RESET: count RESET_CYCLES cycles, then go to ST_FETCH. All outputs stay at reset values.
- ST_FETCH:
  - fetch_req_o = 1; pc_sel_next_o = 0.
  - On fetch_valid_i: latch instr_i into ir, go to ST_EXEC.
  - Waits indefinitely; fetch_valid_i is ignored in every other state.
- ST_EXEC: all decode outputs are a combinational function of ir. Exactly one cycle.
  - LUI, AUIPC, OP-IMM, OP: wr_en_o = 1; pc_sel = 1; next state ST_FETCH.
  - JAL / JALR:
    - wr_en_o = 1; reg_input = 2; pc_sel = 2.
    - ALU computes pc+imm (JAL) or rs1+imm (JALR).
    - The datapath clears bit 0 of the target.
  - BRANCH:
    - wr_en_o = 0; ALU computes pc+imm.
    - pc_sel = 2 if branch_cond_i, else 1.
  - LOAD / STORE: ALU computes rs1+imm; pc_sel = 0; next state ST_MEM.
  - Undecoded opcode: behaves as a NOP (pc_sel = 1, no write), or traps per Optional Feature.
- Write suppression: wr_en_o is forced to 0 whenever rd_idx_o == 0.
- ST_MEM:
  - mem_req_o = 1; mem_we_o = 1 for STORE, 0 for LOAD. Held stable until mem_ready_i.
  - In the mem_ready_i cycle: pc_sel = 1; LOAD also asserts wr_en_o with reg_input = 1. Then go to ST_FETCH.
- Index width:
  - rd/rs1/rs2 are taken from ir[11:7], ir[19:15], ir[24:20], truncated to REG_IDX_W.
  - With REG_IDX_W = 4, any used index with bit 4 set counts as illegal.
- ALU op mapping:
  - OP/OP-IMM: from funct3, plus funct7[5] for SUB/SRA (and SRAI).
  - All other instruction classes use ALU_OP_ADD.
- Latency in cycles, fetch excluded: ALU/jump/branch 1; load/store 1 + wait cycles + 1.

Optional Feature:
- Macro: CONTROL_ILLEGAL_TRAP_EN.
- Defined:
  - An undecoded opcode or an out-of-range RV32E index moves ST_EXEC to ST_TRAP.
  - ST_TRAP: illegal_o = 1, pc_sel = 0, no writes; stays there until reset.
- Undefined:
  - illegal_o is tied to 0 and ST_TRAP is unreachable.
  - Illegal instructions execute as NOPs with pc_sel = 1.

Decomposition:
- Shared package const.v holds: ALU_OP_* codes, opcode constants (OPC_LUI etc.), and the REG_SRC_* and PC_SEL_* encodings.
- One natural sub-module: imm_gen, a purely combinational ir -> 32-bit immediate for the I/S/B/U/J formats.

Test Plan:
- Reset with RESET_CYCLES = 2: fetch_req_o = 0 for the 2 cycles after rstn_i rises, then 1. rstn_i low during ST_MEM -> all outputs 0 in the same cycle.
- LUI 0x123452B7 -> in ST_EXEC: wr_en = 1, rd = 5, imm = 0x12345000, alu_a = 0, pc_sel = 1.
- ADDI 0xFFF00093 -> rd = 1, rs1 = 0, imm = 0xFFFFFFFF, alu_b = 0, ALU_OP_ADD. Same encoding with rd = 0 -> wr_en = 0.
- LW 0x0040A103 with mem_ready_i delayed 3 cycles -> mem_req_o held 4 cycles; wr_en = 1, reg_input = 1, rd = 2 only in the ready cycle.
- BEQ 0x00208463 -> imm = 8. branch_cond_i = 1 -> pc_sel = 2; branch_cond_i = 0 -> pc_sel = 1; wr_en = 0 in both cases.
- Illegal opcode 0x0000007F -> with CONTROL_ILLEGAL_TRAP_EN: illegal_o = 1 and ST_TRAP held until reset. Without it: pc_sel = 1, no write.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I/RV32E control unit: FSM states,
// ALU opcodes, instruction opcodes, register-source and PC-select codes.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_TRAP
    } state_t;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] REG_SRC_ALU = 2'd0;
    localparam logic [1:0] REG_SRC_MEM = 2'd1;
    localparam logic [1:0] REG_SRC_PC4 = 2'd2;

    localparam logic [1:0] PC_SEL_HOLD = 2'd0;
    localparam logic [1:0] PC_SEL_INC  = 2'd1;
    localparam logic [1:0] PC_SEL_ALU  = 2'd2;

    // funct7[5] selects SUB only for register-register ops; ADDI ignores it
    function automatic logic [3:0] alu_op_decode(input logic [2:0] funct3,
                                                 input logic       funct7_b5,
                                                 input logic       is_reg_op);
        case (funct3)
            3'd0:    return (is_reg_op && funct7_b5) ? ALU_OP_SUB : ALU_OP_ADD;
            3'd1:    return ALU_OP_SLL;
            3'd2:    return ALU_OP_SLT;
            3'd3:    return ALU_OP_SLTU;
            3'd4:    return ALU_OP_XOR;
            3'd5:    return funct7_b5 ? ALU_OP_SRA : ALU_OP_SRL;
            3'd6:    return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_imm_gen.sv
// Combinational immediate generator: instruction word -> sign-extended
// I/S/B/U/J immediate, zero for formats without an immediate.
module control_fsm_imm_gen
    import control_fsm_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (ir_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_o = {{20{ir_i[31]}}, ir_i[31:20]};
            OPC_STORE:
                imm_o = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            OPC_BRANCH:
                imm_o = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25],
                         ir_i[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_o = {ir_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20],
                         ir_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I/RV32E control unit (reset/fetch/exec/mem/trap).
// Define CONTROL_ILLEGAL_TRAP_EN to trap illegal instructions instead of NOPing them.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned REG_IDX_W    = 5,
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    output logic                 fetch_req_o,
    input  logic                 fetch_valid_i,
    input  logic [31:0]          instr_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    input  logic                 mem_ready_i,
    input  logic                 branch_cond_i,
    output logic                 wr_en_o,
    output logic [REG_IDX_W-1:0] rd_idx_o,
    output logic [REG_IDX_W-1:0] rs1_idx_o,
    output logic [REG_IDX_W-1:0] rs2_idx_o,
    output logic [31:0]          imm_data_o,
    output logic [3:0]           alu_ctrl_o,
    output logic                 alu_a_input_o,
    output logic                 alu_b_input_o,
    output logic [1:0]           reg_input_o,
    output logic [1:0]           pc_sel_next_o,
    output logic                 illegal_o
);

    localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ir_q;
    logic             ir_load;
    logic             wr_en_raw;

    logic [6:0] opcode;
    logic is_lui, is_auipc, is_op_imm, is_op, is_load, is_store;
    logic is_jal, is_jalr, is_branch, decoded;
    logic uses_rd, uses_rs1, uses_rs2, idx_oob, illegal_instr;

    assign opcode    = ir_q[6:0];
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign decoded   = is_lui | is_auipc | is_op_imm | is_op | is_load |
                       is_store | is_jal | is_jalr | is_branch;

    assign uses_rd  = is_lui | is_auipc | is_op_imm | is_op | is_load | is_jal | is_jalr;
    assign uses_rs1 = is_op_imm | is_op | is_load | is_store | is_jalr | is_branch;
    assign uses_rs2 = is_op | is_store | is_branch;

    always_comb begin
        idx_oob = 1'b0;
        if (REG_IDX_W < 5) begin
            idx_oob = (uses_rd & ir_q[11]) | (uses_rs1 & ir_q[19]) | (uses_rs2 & ir_q[24]);
        end
    end

    assign illegal_instr = ~decoded | idx_oob;

    // LUI reads x0 as operand A so the ALU result is the bare U-immediate
    assign rd_idx_o  = ir_q[7 +: REG_IDX_W];
    assign rs1_idx_o = is_lui ? '0 : ir_q[15 +: REG_IDX_W];
    assign rs2_idx_o = ir_q[20 +: REG_IDX_W];

    control_fsm_imm_gen u_imm_gen (
        .ir_i  (ir_q),
        .imm_o (imm_data_o)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ir_load) begin
                ir_q <= instr_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ir_load       = 1'b0;
        fetch_req_o   = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        wr_en_raw     = 1'b0;
        alu_ctrl_o    = ALU_OP_ADD;
        alu_a_input_o = 1'b0;
        alu_b_input_o = 1'b0;
        reg_input_o   = REG_SRC_ALU;
        pc_sel_next_o = PC_SEL_HOLD;
        illegal_o     = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_FETCH: begin
                fetch_req_o = 1'b1;
                if (fetch_valid_i) begin
                    ir_load = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d       = ST_FETCH;
                alu_a_input_o = is_auipc | is_jal | is_branch;
                alu_b_input_o = is_op;
                if (is_op | is_op_imm) begin
                    alu_ctrl_o = alu_op_decode(ir_q[14:12], ir_q[30], is_op);
                end

                if (illegal_instr) begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    pc_sel_next_o = PC_SEL_INC;
`endif
                end else if (is_lui | is_auipc | is_op_imm | is_op) begin
                    wr_en_raw     = 1'b1;
                    pc_sel_next_o = PC_SEL_INC;
                end else if (is_jal | is_jalr) begin
                    wr_en_raw     = 1'b1;
                    reg_input_o   = REG_SRC_PC4;
                    pc_sel_next_o = PC_SEL_ALU;
                end else if (is_branch) begin
                    pc_sel_next_o = branch_cond_i ? PC_SEL_ALU : PC_SEL_INC;
                end else begin
                    state_d = ST_MEM;
                end
            end

            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = is_store;
                if (mem_ready_i) begin
                    pc_sel_next_o = PC_SEL_INC;
                    if (is_load) begin
                        wr_en_raw   = 1'b1;
                        reg_input_o = REG_SRC_MEM;
                    end
                    state_d = ST_FETCH;
                end
            end

            ST_TRAP: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                illegal_o = 1'b1;
`endif
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    assign wr_en_o = wr_en_raw & (rd_idx_o != '0);

endmodule
